// File: rtl/ntt_pkg.sv
// Shared types, constants and modular-arithmetic helpers for the iterative NTT core.
// The helpers operate on NTT_MAX_W-bit words, so callers must keep W <= NTT_MAX_W.
package ntt_pkg;

  localparam int unsigned NTT_MAX_N     = 256;
  localparam int unsigned NTT_MAX_LOGN  = 8;
  localparam int unsigned NTT_LOGN_BITS = $clog2(NTT_MAX_LOGN);
  localparam int unsigned NTT_MAX_W     = 32;

  typedef enum logic [1:0] {
    StLoad,
    StCompute,
    StUnload
  } ntt_state_e;

  typedef logic [NTT_MAX_W-1:0]    ntt_word_t;
  typedef logic [NTT_MAX_LOGN-1:0] ntt_idx_t;

  // Reverses the low logn bits of idx; higher bits of the result are zero.
  function automatic ntt_idx_t bitrev(ntt_idx_t idx, int unsigned logn);
    ntt_idx_t r;
    r = '0;
    for (int unsigned i = 0; i < NTT_MAX_LOGN; i++) begin
      if (i < logn) begin
        r[NTT_LOGN_BITS'(logn - 1 - i)] = idx[NTT_LOGN_BITS'(i)];
      end
    end
    return r;
  endfunction

  function automatic ntt_word_t modadd(ntt_word_t a, ntt_word_t b, ntt_word_t q);
    logic [NTT_MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return ntt_word_t'(s % {1'b0, q});
  endfunction

  function automatic ntt_word_t modmul(ntt_word_t a, ntt_word_t b, ntt_word_t q);
    logic [2*NTT_MAX_W-1:0] p;
    p = {{NTT_MAX_W{1'b0}}, a} * {{NTT_MAX_W{1'b0}}, b};
    return ntt_word_t'(p % {{NTT_MAX_W{1'b0}}, q});
  endfunction

endpackage

// File: rtl/ntt_bfly.sv
// Combinational Cooley-Tukey butterfly over Z_q: A' = A + C*w, C' = A + C*(q-w), both mod q.
module ntt_bfly #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] c,
  input  logic [W-1:0] w,
  input  logic [W-1:0] q,
  output logic [W-1:0] a_new,
  output logic [W-1:0] c_new
);

  logic [W:0]     w_neg;
  logic [2*W-1:0] prod_p;
  logic [2*W-1:0] prod_n;
  logic [2*W:0]   sum_p;
  logic [2*W:0]   sum_n;

  always_comb begin
    // w == 0 yields q here, which the final reduction folds back to zero.
    w_neg  = {1'b0, q} - {1'b0, w};
    prod_p = (2*W)'(c) * (2*W)'(w);
    prod_n = (2*W)'(c) * (2*W)'(w_neg);
    sum_p  = (2*W+1)'(a) + (2*W+1)'(prod_p);
    sum_n  = (2*W+1)'(a) + (2*W+1)'(prod_n);
    a_new  = W'(sum_p % (2*W+1)'(q));
    c_new  = W'(sum_n % (2*W+1)'(q));
  end

endmodule

// File: rtl/ntt_iter_core.sv
// Iterative radix-2 NTT: load N coefficients (bit-reversed), run LOGN in-place stages at one
// butterfly per cycle, unload N results in natural order. NTT_INV_EN adds inverse-transform scaling.
module ntt_iter_core
  import ntt_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned N    = 8,
  parameter int unsigned LOGN = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         mod,
  input  logic [(N/2)*W-1:0]   tw,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
`ifdef NTT_INV_EN
  input  logic                 inv,
  input  logic [W-1:0]         n_inv,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(LOGN + 1);
  localparam int unsigned BW = LOGN - 1;

  localparam logic [LOGN-1:0] IdxLast   = LOGN'(N - 1);
  localparam logic [BW-1:0]   BflyLast  = BW'(N / 2 - 1);
  localparam logic [SW-1:0]   StageLast = SW'(LOGN - 1);

  ntt_state_e           state_q, state_d;
  logic [LOGN-1:0]      idx_q, idx_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [BW-1:0]        bfly_q, bfly_d;
  logic [W-1:0]         mod_q, mod_d;
  logic [(N/2)*W-1:0]   tw_q, tw_d;
  logic [W-1:0]         mem_q [N];
  logic [W-1:0]         mem_d [N];

  logic [W-1:0]         tw_arr [N/2];
  logic [LOGN-1:0]      load_addr;
  logic                 load_first;
  logic [LOGN-1:0]      bfly_ext, half, bf_j, grp_base, bf_a, bf_c;
  logic [SW-1:0]        tw_shift;
  logic [BW-1:0]        tw_idx;
  logic [W-1:0]         bf_w, bf_a_new, bf_c_new;
  logic [W-1:0]         unload_word;

  always_comb begin
    for (int j = 0; j < N / 2; j++) begin
      tw_arr[j] = tw_q[j*W +: W];
    end
  end

  assign load_addr  = LOGN'(bitrev(NTT_MAX_LOGN'(idx_q), LOGN));
  assign load_first = (state_q == StLoad) && in_valid && (idx_q == '0);

  // Butterfly b of stage s pairs a = (b / h) * 2h + b % h with c = a + h, twiddle index j * N/(2h).
  always_comb begin
    bfly_ext = {1'b0, bfly_q};
    half     = LOGN'(1) << stage_q;
    bf_j     = bfly_ext & (half - LOGN'(1));
    grp_base = (bfly_ext >> stage_q) << (stage_q + SW'(1));
    bf_a     = grp_base | bf_j;
    bf_c     = bf_a | half;
    tw_shift = StageLast - stage_q;
    tw_idx   = BW'(bf_j << tw_shift);
    bf_w     = tw_arr[tw_idx];
  end

  ntt_bfly #(
    .W(W)
  ) u_bfly (
    .a    (mem_q[bf_a]),
    .c    (mem_q[bf_c]),
    .w    (bf_w),
    .q    (mod_q),
    .a_new(bf_a_new),
    .c_new(bf_c_new)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    mod_d     = mod_q;
    tw_d      = tw_q;
    mem_d     = mem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          mem_d[load_addr] = in_data;
          if (load_first) begin
            mod_d = mod;
            tw_d  = tw;
          end
          if (idx_q == IdxLast) begin
            state_d = StCompute;
            idx_d   = '0;
            stage_d = '0;
            bfly_d  = '0;
          end else begin
            idx_d = idx_q + LOGN'(1);
          end
        end
      end
      StCompute: begin
        mem_d[bf_a] = bf_a_new;
        mem_d[bf_c] = bf_c_new;
        if (bfly_q == BflyLast) begin
          bfly_d = '0;
          if (stage_q == StageLast) begin
            state_d = StUnload;
            stage_d = '0;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end else begin
          bfly_d = bfly_q + BW'(1);
        end
      end
      StUnload: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == IdxLast) begin
            state_d = StLoad;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + LOGN'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      idx_q   <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      mod_q   <= '0;
      tw_q    <= '0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      mod_q   <= mod_d;
      tw_q    <= tw_d;
      mem_q   <= mem_d;
    end
  end

  assign unload_word = mem_q[idx_q];
  assign out_last    = (state_q == StUnload) && (idx_q == IdxLast);

`ifdef NTT_INV_EN
  logic         inv_q;
  logic [W-1:0] n_inv_q;
  logic [W-1:0] scaled_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q   <= 1'b0;
      n_inv_q <= '0;
    end else if (load_first) begin
      inv_q   <= inv;
      n_inv_q <= n_inv;
    end
  end

  // Scaling sits on the read path so stalls simply hold the stored word.
  assign scaled_word = W'(modmul(NTT_MAX_W'(unload_word), NTT_MAX_W'(n_inv_q),
                                 NTT_MAX_W'(mod_q)));
  assign out_data    = !out_valid ? '0 : (inv_q ? scaled_word : unload_word);
`else
  assign out_data    = out_valid ? unload_word : '0;
`endif

endmodule

// File: doc/ntt_iter_core.md
Name: ntt_iter_core

Overview:
- Parametrised, iterative radix-2 Cooley-Tukey NTT engine over Z_mod; generalises the fixed 8-point combinational butterfly network to N points of W bits.
- Streams N coefficients in, runs log2(N) in-place butterfly stages at one butterfly per cycle, then streams N results out.
- Sits between the coefficient source and the pointwise-multiply stage of the NTT datapath.

Parameters:
- W, 8, coefficient/modulus width in bits.
- N, 8, transform length; power of two, 4..256.
- LOGN, $clog2(N), derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mod  in  W  modulus q; must be ≥2
- tw  in  (N/2)*W  twiddle table; tw[j] = ω^j for j=0..N/2-1, slice j at bits [j*W +: W]
- in_valid  in  1  input coefficient valid
- in_ready  out  1  core accepts a coefficient
- in_data  in  W  input coefficient, natural order, < mod
- out_valid  out  1  result coefficient valid
- out_ready  in  1  sink accepts a result
- out_data  out  W  result X[k], natural order
- out_last  out  1  high with X[N-1]
- busy  out  1  high in COMPUTE and UNLOAD

Behaviour:
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0; counters and the coefficient array are cleared to 0.
- Reset asserted in any state aborts the transform immediately. No partial output follows reset release.
- FSM states: LOAD, COMPUTE, UNLOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready stores in_data at address bitrev(idx), idx=0..N-1.
  - mod and tw are latched on the first accepted beat (idx=0). Later changes are ignored until the next LOAD.
  - After beat N-1, go to COMPUTE on the next edge.
- COMPUTE:
  - in_ready=0.
  - Stage s=0..LOGN-1: half-span h=2^s. Butterfly b=0..N/2-1: group g=b/h, j=b%h, a=g*2h+j, c=a+h, w=tw[j*(N/(2h))].
  - Each butterfly takes one cycle, read-modify-write on the register array:
    - A' = (A + C*w) mod q
    - C' = (A + C*(q-w)) mod q
  - Arithmetic widths: product 2W bits, sum 2W+1 bits, reduced by modulo; no truncation before reduction.
  - w=0 gives (q-0)=q, which reduces correctly.
  - Total COMPUTE = LOGN*N/2 cycles (12 for N=8). Then go to UNLOAD.
- UNLOAD:
  - out_valid=1; out_data=array[k] with k=0..N-1.
  - out_data is held stable while out_ready=0.
  - Advance k on out_valid&out_ready. out_last=1 when k=N-1.
  - After the last handshake: out_valid=0, busy=0, next state LOAD.
  - in_ready stays 0 until LOAD is entered; no overlap between frames.
- Edge cases:
  - in_valid while not in LOAD is ignored.
  - Inputs ≥ mod are undefined; no check is made.
  - The first LOAD beat after UNLOAD may be accepted on the cycle LOAD is entered.

Optional Feature:
- Macro: NTT_INV_EN.
- Defined:
  - Adds ports inv (in, 1) and n_inv (in, W). Both are latched with mod on the first LOAD beat.
  - When inv=1: tw is taken to hold ω^-j, and each result is multiplied by n_inv mod q on the unload path.
  - out_data remains stable under stall. Unload timing is unchanged.
  - When inv=0: behaviour is identical to the undefined build.
- Undefined: no extra ports; forward transform only.

Decomposition:
- Package ntt_pkg:
  - state enum {LOAD, COMPUTE, UNLOAD}
  - bitrev function (parametrised by LOGN)
  - modmul/modadd helper functions
  - NTT_MAX_N=256 constant
- Sub-module ntt_bfly: combinational (A, C, w, q) -> (A', C'). It is instanced once and parametrised by W.

Test Plan:
- N=8, q=17, tw={1,2,4,8} (ω=2), input {1,0,0,0,0,0,0,0} -> out {1,1,1,1,1,1,1,1}, out_last on the 8th beat, in_ready low for 12+8 handshake cycles.
- Same tw/q, input {0,1,0,0,0,0,0,0} -> out {1,2,4,8,16,15,13,9}.
- Same tw/q, input all 1 -> out {8,0,0,0,0,0,0,0}.
- Input {0,1,...}; hold out_ready=0 for 5 cycles at k=3 -> out_data stays 8, out_valid stays 1, and no beat is lost or duplicated.
- Assert rst_n=0 during cycle 6 of COMPUTE, then reload impulse {1,0,...} -> all outputs reset immediately; the second frame gives all 1s and no residue from the aborted frame.
- NTT_INV_EN build: forward of {0,1,0,...}, then inverse with tw={1,9,13,15}, n_inv=15 on {1,2,4,8,16,15,13,9} -> out {0,1,0,0,0,0,0,0}.
